// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with fetch lead and 2x doubling.
// Fetch coordinates are issued LEAD pixel enables ahead of the display-aligned strobes.
module vga_timing_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic SYNC_POL = 1'b0,
    parameter int   LEAD     = 2,
    localparam int  H_TOT    = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int  V_TOT    = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int  HW       = $clog2(H_TOT),
    localparam int  VW       = $clog2(V_TOT)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pix_en,
    input  logic          dbl,
    input  logic          irq_ack,
    output logic [HW-1:0] fetch_x,
    output logic [VW-1:0] fetch_y,
    output logic          fetch_valid,
    output logic          h_sync_o,
    output logic          v_sync_o,
    output logic          de,
    output logic          line_start,
    output logic          frame_start,
    output logic          irq_o
);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOT - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOT - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    // One extra bit so a sync window ending exactly at a power of two still compares
    localparam logic [HW:0]   HS_BEG = (HW+1)'(H_ACTIVE + H_FP);
    localparam logic [HW:0]   HS_END = (HW+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW:0]   VS_BEG = (VW+1)'(V_ACTIVE + V_FP);
    localparam logic [VW:0]   VS_END = (VW+1)'(V_ACTIVE + V_FP + V_SYNC);

    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
        logic ls;
        logic fs;
    } disp_t;

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          dbl_q;
    disp_t         s0;
    disp_t         raw;
    disp_t         disp;
    logic          act;
    logic          irq_set;

    always_comb begin
        raw    = '0;
        raw.hs = ({1'b0, h_cnt} >= HS_BEG) && ({1'b0, h_cnt} < HS_END);
        raw.vs = ({1'b0, v_cnt} >= VS_BEG) && ({1'b0, v_cnt} < VS_END);
        act    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        raw.de = act;
        raw.ls = (h_cnt == '0);
        raw.fs = (h_cnt == '0) && (v_cnt == '0);
        irq_set = pix_en && (h_cnt == '0) && (v_cnt == V_ACT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_en) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    // Doubling mode only changes at the frame origin so a frame is never mixed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbl_q <= 1'b0;
        end else if (pix_en && raw.fs) begin
            dbl_q <= dbl;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0          <= '0;
            fetch_valid <= 1'b0;
            fetch_x     <= '0;
            fetch_y     <= '0;
        end else if (pix_en) begin
            s0          <= raw;
            fetch_valid <= act;
            if (act) begin
                fetch_x <= dbl_q ? (h_cnt >> 1) : h_cnt;
                fetch_y <= dbl_q ? (v_cnt >> 1) : v_cnt;
            end
        end
    end

    generate
        if (LEAD == 0) begin : g_nolead
            assign disp = s0;
        end else begin : g_lead
            disp_t pipe [LEAD];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < LEAD; i++) begin
                        pipe[i] <= '0;
                    end
                end else if (pix_en) begin
                    pipe[0] <= s0;
                    for (int i = 1; i < LEAD; i++) begin
                        pipe[i] <= pipe[i-1];
                    end
                end
            end

            assign disp = pipe[LEAD-1];
        end
    endgenerate

    // A set on the same clock as an ack wins so no vblank is lost
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_o <= 1'b0;
        end else if (irq_set) begin
            irq_o <= 1'b1;
        end else if (irq_ack) begin
            irq_o <= 1'b0;
        end
    end

    assign h_sync_o    = disp.hs ^ ~SYNC_POL;
    assign v_sync_o    = disp.vs ^ ~SYNC_POL;
    assign de          = disp.de;
    assign line_start  = disp.ls;
    assign frame_start = disp.fs;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a shrunken 24x12 raster.
// Expected samples are queued by cycle; a negedge monitor pops and compares.
module tb_vga_timing_gen;

    localparam int HW = 5;
    localparam int VW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pix_en = 1'b1;
    logic          dbl = 1'b0;
    logic          irq_ack = 1'b0;
    logic [HW-1:0] fetch_x;
    logic [VW-1:0] fetch_y;
    logic          fetch_valid, h_sync_o, v_sync_o, de;
    logic          line_start, frame_start, irq_o;
    logic [HW-1:0] b_fx;
    logic [VW-1:0] b_fy;
    logic          b_fv, b_hs, b_vs, b_de, b_ls, b_fs, b_irq;

    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_POL(1'b0), .LEAD(2)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .dbl(dbl),
        .irq_ack(irq_ack), .fetch_x(fetch_x), .fetch_y(fetch_y),
        .fetch_valid(fetch_valid), .h_sync_o(h_sync_o),
        .v_sync_o(v_sync_o), .de(de), .line_start(line_start),
        .frame_start(frame_start), .irq_o(irq_o)
    );

    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_POL(1'b1), .LEAD(0)
    ) u_alt (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .dbl(dbl),
        .irq_ack(irq_ack), .fetch_x(b_fx), .fetch_y(b_fy),
        .fetch_valid(b_fv), .h_sync_o(b_hs), .v_sync_o(b_vs),
        .de(b_de), .line_start(b_ls), .frame_start(b_fs),
        .irq_o(b_irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    cyc;
        int    id;
        int    exp;
        string nm;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   passed = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int get_sig(int id);
        case (id)
            0:  return int'(de);
            1:  return int'(h_sync_o);
            2:  return int'(v_sync_o);
            3:  return int'(line_start);
            4:  return int'(frame_start);
            5:  return int'(irq_o);
            6:  return int'(fetch_valid);
            7:  return int'(fetch_x);
            8:  return int'(fetch_y);
            9:  return int'(b_de);
            10: return int'(b_hs);
            default: return -1;
        endcase
    endfunction

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    task automatic push(int c, int id, int v, string nm);
        sb.push_back('{c, id, v, nm});
    endtask

    always @(negedge clk) begin
        int i;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].cyc == cyc) begin
                chk(sb[i].nm, get_sig(sb[i].id), sb[i].exp);
                sb.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic wait_cyc(int c);
        do @(negedge clk); while (cyc < c);
        #1;
    endtask

    task automatic push_reset(int c);
        push(c, 0, 0, "rst_de");
        push(c, 1, 1, "rst_hs");
        push(c, 2, 1, "rst_vs");
        push(c, 3, 0, "rst_ls");
        push(c, 4, 0, "rst_fs");
        push(c, 5, 0, "rst_irq");
        push(c, 6, 0, "rst_fv");
        push(c, 7, 0, "rst_fx");
        push(c, 8, 0, "rst_fy");
        push(c, 9, 0, "rst_alt_de");
        push(c, 10, 0, "rst_alt_hs");
    endtask

    task automatic release_rst(output int b);
        int c0;
        c0 = cyc;
        push_reset(c0 + 1);
        wait_cyc(c0 + 1);
        rst_n = 1'b1;
        b = c0 + 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        int b2;
        wait_cyc(3);
        release_rst(b);

        push(b+1, 6, 1, "fv_first");
        push(b+1, 7, 0, "fx_first");
        push(b+1, 8, 0, "fy_first");
        push(b+1, 9, 1, "alt_de_lead0");
        push(b+2, 7, 1, "fx_1");
        push(b+2, 0, 0, "de_pre");
        push(b+3, 0, 1, "de_rise");
        push(b+3, 4, 1, "fs_first");
        push(b+3, 3, 1, "ls_first");
        push(b+4, 4, 0, "fs_pulse_end");
        push(b+4, 3, 0, "ls_pulse_end");
        push(b+16, 7, 15, "fx_15");
        push(b+17, 6, 0, "fv_blank");
        push(b+17, 7, 15, "fx_hold");
        push(b+18, 0, 1, "de_last");
        push(b+19, 0, 0, "de_fall");
        push(b+18, 10, 0, "alt_hs_idle");
        push(b+19, 10, 1, "alt_hs_active");
        push(b+20, 1, 1, "hs_pre");
        push(b+21, 1, 0, "hs_start");
        push(b+23, 1, 0, "hs_last");
        push(b+24, 1, 1, "hs_end");
        push(b+25, 7, 0, "fx_line1");
        push(b+25, 8, 1, "fy_line1");
        push(b+27, 3, 1, "ls_line1");
        push(b+27, 4, 0, "fs_line1");
        push(b+128, 7, 7, "fx_unscaled");
        push(b+128, 8, 5, "fy_unscaled");
        push(b+192, 5, 0, "irq_pre");
        push(b+193, 5, 1, "irq_set_wins");
        push(b+194, 5, 1, "irq_sticky");
        push(b+195, 0, 0, "de_vblank");
        push(b+197, 5, 1, "irq_hold");
        push(b+198, 5, 0, "irq_acked");
        push(b+218, 2, 1, "vs_pre");
        push(b+219, 2, 0, "vs_start");
        push(b+266, 2, 0, "vs_last");
        push(b+267, 2, 1, "vs_end");
        push(b+290, 4, 0, "fs_pre2");
        push(b+291, 4, 1, "fs_frame2");
        for (int v = 0; v < 8; v++) begin
            for (int h = 0; h < 16; h++) begin
                push(b+289+v*24+h, 7, h/2, "dbl_fx");
                push(b+289+v*24+h, 8, v/2, "dbl_fy");
            end
        end
        push(b+480, 5, 0, "irq_pre2");
        push(b+481, 5, 1, "irq_frame2");
        push(b+612, 5, 1, "pre_rst_irq");
        push(b+612, 0, 1, "pre_rst_de");
        push(b+612, 6, 1, "pre_rst_fv");
        push(b+612, 7, 11, "pre_rst_fx");
        push(b+612, 8, 1, "pre_rst_fy");

        wait_cyc(b+100);
        dbl = 1'b1;
        wait_cyc(b+192);
        irq_ack = 1'b1;
        wait_cyc(b+193);
        irq_ack = 1'b0;
        wait_cyc(b+197);
        irq_ack = 1'b1;
        wait_cyc(b+198);
        irq_ack = 1'b0;
        wait_cyc(b+400);
        dbl = 1'b0;

        wait_cyc(b+612);
        rst_n = 1'b0;
        #1;
        chk("async_de", int'(de), 0);
        chk("async_fv", int'(fetch_valid), 0);
        chk("async_fx", int'(fetch_x), 0);
        chk("async_fy", int'(fetch_y), 0);
        chk("async_hs", int'(h_sync_o), 1);
        chk("async_vs", int'(v_sync_o), 1);
        chk("async_irq", int'(irq_o), 0);
        chk("async_alt_hs", int'(b_hs), 0);

        wait_cyc(b+614);
        pix_en = 1'b1;
        release_rst(b2);

        push(b2+8, 0, 0, "q_de_pre");
        push(b2+8, 4, 0, "q_fs_pre");
        push(b2+9, 0, 1, "q_de_rise");
        push(b2+9, 4, 1, "q_fs");
        push(b2+12, 4, 1, "q_fs_hold");
        push(b2+13, 4, 0, "q_fs_end");
        push(b2+12, 0, 1, "q_de_hold");
        push(b2+72, 0, 1, "q_de_last");
        push(b2+73, 0, 0, "q_de_fall");
        push(b2+80, 1, 1, "q_hs_pre");
        push(b2+81, 1, 0, "q_hs_start");
        push(b2+92, 1, 0, "q_hs_last");
        push(b2+93, 1, 1, "q_hs_end");
        push(b2+104, 3, 0, "q_ls_pre");
        push(b2+105, 3, 1, "q_ls_line1");
        push(b2+21, 7, 5, "q_fx5");
        push(b2+24, 7, 5, "q_fx5_hold");
        push(b2+25, 7, 6, "q_fx6");
        push(b2+770, 5, 1, "q_irq_set");
        push(b2+771, 5, 0, "q_irq_ack_noen");
        push(b2+772, 5, 0, "q_irq_stays");

        for (int e = b2 + 2; e <= b2 + 780; e++) begin
            wait_cyc(e - 1);
            pix_en  = ((e - b2) % 4 == 1);
            irq_ack = (e == b2 + 771);
        end

        wait_cyc(b2 + 782);
        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
